// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register of the five-stage MIPS pipeline.
// Captures operands, register specifiers, immediate, PC+4, funct and the
// main-control bits decoded in ID and presents them to EX one cycle later.
// The hazard unit drives en (0 = stall, hold contents) and flush (insert
// bubble). Flush outranks a stall; the asynchronous active-low rst
// outranks everything.
//
// Optional feature: define ID_EX_VALID_EN to add a valid_ex flag. It is
// set by a normal load and cleared by reset or flush.
module id_ex_register (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,

    input  logic [31:0] pc_plus_4_id,
    input  logic [31:0] read_data_1_id,
    input  logic [31:0] read_data_2_id,
    input  logic [31:0] immediate_id,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rd_id,
    input  logic        ctrl_RegDst_id,
    input  logic        ctrl_ALUSrc_id,
    input  logic        ctrl_MemToReg_id,
    input  logic        ctrl_RegWrite_id,
    input  logic        ctrl_MemRead_id,
    input  logic        ctrl_MemWrite_id,
    input  logic        ctrl_Branch_id,
    input  logic [5:0]  funct_id,
    input  logic [1:0]  ctrl_ALUOp_id,

    output logic [31:0] pc_plus_4_ex,
    output logic [31:0] read_data_1_ex,
    output logic [31:0] read_data_2_ex,
    output logic [31:0] immediate_ex,
    output logic [4:0]  rs_ex,
    output logic [4:0]  rt_ex,
    output logic [4:0]  rd_ex,
    output logic        ctrl_RegDst_ex,
    output logic        ctrl_ALUSrc_ex,
    output logic        ctrl_MemToReg_ex,
    output logic        ctrl_RegWrite_ex,
    output logic        ctrl_MemRead_ex,
    output logic        ctrl_MemWrite_ex,
    output logic        ctrl_Branch_ex,
    output logic [5:0]  funct_ex,
    output logic [1:0]  ctrl_ALUOp_ex
`ifdef ID_EX_VALID_EN
    ,
    output logic        valid_ex
`endif
);

    // ---- ID -> EX stage boundary ----

    // Data fields: PC+4, both register-file operands and the immediate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_plus_4_ex   <= '0;
            read_data_1_ex <= '0;
            read_data_2_ex <= '0;
            immediate_ex   <= '0;
        end else if (flush) begin
            pc_plus_4_ex   <= '0;
            read_data_1_ex <= '0;
            read_data_2_ex <= '0;
            immediate_ex   <= '0;
        end else if (en) begin
            pc_plus_4_ex   <= pc_plus_4_id;
            read_data_1_ex <= read_data_1_id;
            read_data_2_ex <= read_data_2_id;
            immediate_ex   <= immediate_id;
        end
    end

    // Register specifiers and funct; cleared on flush so forwarding and
    // hazard logic never match against a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_ex    <= '0;
            rt_ex    <= '0;
            rd_ex    <= '0;
            funct_ex <= '0;
        end else if (flush) begin
            rs_ex    <= '0;
            rt_ex    <= '0;
            rd_ex    <= '0;
            funct_ex <= '0;
        end else if (en) begin
            rs_ex    <= rs_id;
            rt_ex    <= rt_id;
            rd_ex    <= rd_id;
            funct_ex <= funct_id;
        end
    end

    // Main-control bits; all zero makes the EX stage a NOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_RegDst_ex   <= 1'b0;
            ctrl_ALUSrc_ex   <= 1'b0;
            ctrl_MemToReg_ex <= 1'b0;
            ctrl_RegWrite_ex <= 1'b0;
            ctrl_MemRead_ex  <= 1'b0;
            ctrl_MemWrite_ex <= 1'b0;
            ctrl_Branch_ex   <= 1'b0;
            ctrl_ALUOp_ex    <= 2'b00;
        end else if (flush) begin
            ctrl_RegDst_ex   <= 1'b0;
            ctrl_ALUSrc_ex   <= 1'b0;
            ctrl_MemToReg_ex <= 1'b0;
            ctrl_RegWrite_ex <= 1'b0;
            ctrl_MemRead_ex  <= 1'b0;
            ctrl_MemWrite_ex <= 1'b0;
            ctrl_Branch_ex   <= 1'b0;
            ctrl_ALUOp_ex    <= 2'b00;
        end else if (en) begin
            ctrl_RegDst_ex   <= ctrl_RegDst_id;
            ctrl_ALUSrc_ex   <= ctrl_ALUSrc_id;
            ctrl_MemToReg_ex <= ctrl_MemToReg_id;
            ctrl_RegWrite_ex <= ctrl_RegWrite_id;
            ctrl_MemRead_ex  <= ctrl_MemRead_id;
            ctrl_MemWrite_ex <= ctrl_MemWrite_id;
            ctrl_Branch_ex   <= ctrl_Branch_id;
            ctrl_ALUOp_ex    <= ctrl_ALUOp_id;
        end
    end

`ifdef ID_EX_VALID_EN
    // Valid flag: set by a real load, cleared by reset or bubble, held on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_ex <= 1'b0;
        end else if (flush) begin
            valid_ex <= 1'b0;
        end else if (en) begin
            valid_ex <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Directed testbench for id_ex_register: reset, load, flush, stall,
// flush during stall, and asynchronous reset mid-stream.
`timescale 1ns/1ps
module tb_id_ex_register;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic [31:0] pc_plus_4_id, read_data_1_id, read_data_2_id, immediate_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic        ctrl_RegDst_id, ctrl_ALUSrc_id, ctrl_MemToReg_id, ctrl_RegWrite_id;
    logic        ctrl_MemRead_id, ctrl_MemWrite_id, ctrl_Branch_id;
    logic [5:0]  funct_id;
    logic [1:0]  ctrl_ALUOp_id;

    logic [31:0] pc_plus_4_ex, read_data_1_ex, read_data_2_ex, immediate_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic        ctrl_RegDst_ex, ctrl_ALUSrc_ex, ctrl_MemToReg_ex, ctrl_RegWrite_ex;
    logic        ctrl_MemRead_ex, ctrl_MemWrite_ex, ctrl_Branch_ex;
    logic [5:0]  funct_ex;
    logic [1:0]  ctrl_ALUOp_ex;
`ifdef ID_EX_VALID_EN
    logic        valid_ex;
`endif

    int checks_total;
    int checks_passed;

    id_ex_register dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .flush            (flush),
        .pc_plus_4_id     (pc_plus_4_id),
        .read_data_1_id   (read_data_1_id),
        .read_data_2_id   (read_data_2_id),
        .immediate_id     (immediate_id),
        .rs_id            (rs_id),
        .rt_id            (rt_id),
        .rd_id            (rd_id),
        .ctrl_RegDst_id   (ctrl_RegDst_id),
        .ctrl_ALUSrc_id   (ctrl_ALUSrc_id),
        .ctrl_MemToReg_id (ctrl_MemToReg_id),
        .ctrl_RegWrite_id (ctrl_RegWrite_id),
        .ctrl_MemRead_id  (ctrl_MemRead_id),
        .ctrl_MemWrite_id (ctrl_MemWrite_id),
        .ctrl_Branch_id   (ctrl_Branch_id),
        .funct_id         (funct_id),
        .ctrl_ALUOp_id    (ctrl_ALUOp_id),
        .pc_plus_4_ex     (pc_plus_4_ex),
        .read_data_1_ex   (read_data_1_ex),
        .read_data_2_ex   (read_data_2_ex),
        .immediate_ex     (immediate_ex),
        .rs_ex            (rs_ex),
        .rt_ex            (rt_ex),
        .rd_ex            (rd_ex),
        .ctrl_RegDst_ex   (ctrl_RegDst_ex),
        .ctrl_ALUSrc_ex   (ctrl_ALUSrc_ex),
        .ctrl_MemToReg_ex (ctrl_MemToReg_ex),
        .ctrl_RegWrite_ex (ctrl_RegWrite_ex),
        .ctrl_MemRead_ex  (ctrl_MemRead_ex),
        .ctrl_MemWrite_ex (ctrl_MemWrite_ex),
        .ctrl_Branch_ex   (ctrl_Branch_ex),
        .funct_ex         (funct_ex),
        .ctrl_ALUOp_ex    (ctrl_ALUOp_ex)
`ifdef ID_EX_VALID_EN
        ,
        .valid_ex         (valid_ex)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Packed view of all 7 single-bit controls, RegDst in the MSB.
    function automatic logic [6:0] ctrl_bits_ex();
        return {ctrl_RegDst_ex, ctrl_ALUSrc_ex, ctrl_MemToReg_ex, ctrl_RegWrite_ex,
                ctrl_MemRead_ex, ctrl_MemWrite_ex, ctrl_Branch_ex};
    endfunction

    task automatic set_ctrl(input logic [6:0] c);
        {ctrl_RegDst_id, ctrl_ALUSrc_id, ctrl_MemToReg_id, ctrl_RegWrite_id,
         ctrl_MemRead_id, ctrl_MemWrite_id, ctrl_Branch_id} = c;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pc"},    {32'h0, pc_plus_4_ex}, 64'h0);
        check({tag, ".rd1"},   {32'h0, read_data_1_ex}, 64'h0);
        check({tag, ".rd2"},   {32'h0, read_data_2_ex}, 64'h0);
        check({tag, ".imm"},   {32'h0, immediate_ex}, 64'h0);
        check({tag, ".regs"},  {49'h0, rs_ex, rt_ex, rd_ex}, 64'h0);
        check({tag, ".funct"}, {58'h0, funct_ex}, 64'h0);
        check({tag, ".aluop"}, {62'h0, ctrl_ALUOp_ex}, 64'h0);
        check({tag, ".ctrl"},  {57'h0, ctrl_bits_ex()}, 64'h0);
`ifdef ID_EX_VALID_EN
        check({tag, ".valid"}, {63'h0, valid_ex}, 64'h0);
`endif
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst   = 1'b1;
        en    = 1'b1;
        flush = 1'b0;
        pc_plus_4_id   = 32'hAABBCCDD;
        read_data_1_id = 32'h11;
        read_data_2_id = 32'h22;
        immediate_id   = 32'h33;
        rs_id = 5'd1;
        rt_id = 5'd2;
        rd_id = 5'd3;
        funct_id      = 6'b101010;
        ctrl_ALUOp_id = 2'b10;
        set_ctrl(7'b1111111);

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1 check_all_zero("rst_async");
        step();
        step();
        check_all_zero("rst_held");

        // Normal load
        rst = 1'b1;
        step();
        check("load.pc",    {32'h0, pc_plus_4_ex}, 64'hAABBCCDD);
        check("load.rd1",   {32'h0, read_data_1_ex}, 64'h11);
        check("load.rd2",   {32'h0, read_data_2_ex}, 64'h22);
        check("load.imm",   {32'h0, immediate_ex}, 64'h33);
        check("load.rs",    {59'h0, rs_ex}, 64'd1);
        check("load.rt",    {59'h0, rt_ex}, 64'd2);
        check("load.rd",    {59'h0, rd_ex}, 64'd3);
        check("load.funct", {58'h0, funct_ex}, 64'h2A);
        check("load.aluop", {62'h0, ctrl_ALUOp_ex}, 64'h2);
        check("load.ctrl",  {57'h0, ctrl_bits_ex()}, 64'h7F);
`ifdef ID_EX_VALID_EN
        check("load.valid", {63'h0, valid_ex}, 64'h1);
`endif

        // Distinct control pattern to catch swapped bits
        set_ctrl(7'b1010010);
        ctrl_ALUOp_id = 2'b01;
        step();
        check("load2.ctrl",  {57'h0, ctrl_bits_ex()}, 64'h52);
        check("load2.aluop", {62'h0, ctrl_ALUOp_ex}, 64'h1);
        set_ctrl(7'b1111111);
        ctrl_ALUOp_id = 2'b10;
        step();

        // Flush one edge
        flush = 1'b1;
        step();
        check_all_zero("flush");
        flush = 1'b0;

        // Stall: load, then hold across two edges with changed input
        step();
        check("stall_pre.pc", {32'h0, pc_plus_4_ex}, 64'hAABBCCDD);
        en = 1'b0;
        pc_plus_4_id = 32'hFFFFFFFF;
        rd_id = 5'd31;
        step();
        step();
        check("stall.pc", {32'h0, pc_plus_4_ex}, 64'hAABBCCDD);
        check("stall.rd", {59'h0, rd_ex}, 64'd3);
`ifdef ID_EX_VALID_EN
        check("stall.valid", {63'h0, valid_ex}, 64'h1);
`endif

        // Flush during stall wins
        flush = 1'b1;
        step();
        check_all_zero("flush_stall");
        flush = 1'b0;
        step();
        check("post_flush_hold.pc", {32'h0, pc_plus_4_ex}, 64'h0);

        // Resume loading
        en = 1'b1;
        pc_plus_4_id = 32'h12345678;
        step();
        check("resume.pc", {32'h0, pc_plus_4_ex}, 64'h12345678);
        check("resume.rd", {59'h0, rd_ex}, 64'd31);

        // Async reset pulse between edges
        #1 rst = 1'b0;
        #1 check_all_zero("rst_mid");
        en = 1'b0;
        #1 rst = 1'b1;
        step();
        check("rst_rel_hold.pc", {32'h0, pc_plus_4_ex}, 64'h0);
`ifdef ID_EX_VALID_EN
        check("rst_rel_hold.valid", {63'h0, valid_ex}, 64'h0);
`endif
        en = 1'b1;
        step();
        check("rst_rel_load.pc", {32'h0, pc_plus_4_ex}, 64'h12345678);
`ifdef ID_EX_VALID_EN
        check("rst_rel_load.valid", {63'h0, valid_ex}, 64'h1);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the five-stage MIPS pipeline. It captures the decoded operands, register specifiers, immediate, PC+4 and control bits produced in ID, and presents them to EX one cycle later. It supports a stall (hold) via `en` and a bubble insert via `flush`, which are driven by the hazard unit.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  load enable; 0 holds the current contents (stall).
- `flush`  in  1  synchronous clear to bubble.
- `pc_plus_4_id`  in  32  PC+4 of the ID instruction.
- `read_data_1_id`, `read_data_2_id`  in  32 each  register-file read data.
- `immediate_id`  in  32  sign-extended immediate.
- `rs_id`, `rt_id`, `rd_id`  in  5 each  register specifiers.
- `ctrl_RegDst_id`, `ctrl_ALUSrc_id`, `ctrl_MemToReg_id`, `ctrl_RegWrite_id`, `ctrl_MemRead_id`, `ctrl_MemWrite_id`, `ctrl_Branch_id`  in  1 each  main-control bits.
- `funct_id`  in  6  instruction funct field.
- `ctrl_ALUOp_id`  in  2  ALU op class.
- `*_ex` outputs: one registered output per `*_id` input above, with the same name and `_ex` suffix, the same width, and direction out.
- `valid_ex`  out  1  present only with `ID_EX_VALID_EN`.

## Operation
- All outputs are driven directly from flops. There is no combinational path from input to output.
- Priority, highest first: `rst`, then `flush`, then `en`, then hold.
- `rst`=0: all outputs clear to 0 immediately, without waiting for a clock edge, and stay 0 while `rst` is low.
- `flush`=1 at a rising edge: every field is cleared to 0 on that edge. This includes data, specifiers, `funct` and all control bits, so the stage becomes a NOP. Flush wins even when `en`=0.
- `flush`=0, `en`=1: every `*_ex` output takes its `*_id` input value on the edge.
- `flush`=0, `en`=0: all outputs keep their values. Input changes are ignored.
- The block does no arithmetic and does not transform any field. Each field is a straight copy at its declared width.

## Timing
- Latency: 1 cycle from ID input to EX output.
- Reset value of every output is 0, including `pc_plus_4_ex`, all data, all specifiers, `funct_ex` and `ctrl_ALUOp_ex`.
- Reset assertion is asynchronous. Release is sampled at the next rising edge: the first load occurs on the first edge where `rst`=1.
- Simultaneous `flush` and `en`=0: the flush takes effect.
- `flush` held for N cycles: N consecutive bubbles.
- `en` low for N cycles: the same instruction is held for N cycles. Loading resumes on the first edge with `en`=1.
- Reset asserted mid-stall or mid-flush: outputs go to 0 immediately.

## Configuration
- Macro: `ID_EX_VALID_EN`.
- Defined:
  - Adds output `valid_ex`.
  - It resets to 0 and clears to 0 on flush.
  - It is set to 1 on a normal load with `en`=1 and `flush`=0.
  - It holds when `en`=0.
- Undefined: the `valid_ex` port and its flop do not exist. All other behaviour is identical.

## Test plan
- Reset: drive `rst`=0 with inputs `pc_plus_4_id`=AABBCCDD, `rd_id`=3 and all control bits 1 -> all outputs 0 before any clock edge, and they remain 0 across edges while `rst`=0.
- Normal load: `rst`=1, `en`=1, `flush`=0, inputs as above plus `read_data_1_id`=11, `read_data_2_id`=22, `immediate_id`=33 (hex), `rs`/`rt`=1/2, `funct`=101010, `ALUOp`=10 -> after one edge every `*_ex` equals its input (`rd_ex`=3, `pc_plus_4_ex`=AABBCCDD).
- Flush: from the loaded state, `flush`=1 for one edge -> all outputs 0 (`rd_ex`=0, `ctrl_RegWrite_ex`=0).
- Stall: load AABBCCDD, then set `en`=0 and `pc_plus_4_id`=FFFFFFFF for two edges -> `pc_plus_4_ex` stays AABBCCDD.
- Flush during stall: `en`=0, `flush`=1 -> outputs 0 after the edge.
- Async reset mid-stream: load values, then pulse `rst`=0 between edges -> outputs 0 without a clock edge. With `ID_EX_VALID_EN` defined, `valid_ex` goes 1 to 0 and returns to 1 only after the next enabled, non-flushed edge.
